// File: rtl/alu_status_pkg.sv
// Shared definitions for the ALU/status execution stage: op codes, P flag bit
// positions, the reset value of P and small helpers for the status register.
package alu_status_pkg;

    localparam logic [3:0] OP_ADC    = 4'h0;
    localparam logic [3:0] OP_SBC    = 4'h1;
    localparam logic [3:0] OP_AND    = 4'h2;
    localparam logic [3:0] OP_ORA    = 4'h3;
    localparam logic [3:0] OP_EOR    = 4'h4;
    localparam logic [3:0] OP_ASL    = 4'h5;
    localparam logic [3:0] OP_LSR    = 4'h6;
    localparam logic [3:0] OP_ROL    = 4'h7;
    localparam logic [3:0] OP_ROR    = 4'h8;
    localparam logic [3:0] OP_INC    = 4'h9;
    localparam logic [3:0] OP_DEC    = 4'hA;
    localparam logic [3:0] OP_CMP    = 4'hB;
    localparam logic [3:0] OP_BIT    = 4'hC;
    localparam logic [3:0] OP_PASS   = 4'hD;
    localparam logic [3:0] OP_ADD    = 4'hE;
    localparam logic [3:0] OP_PASSNF = 4'hF;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_ONE = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    localparam logic [7:0] RESET_P_DEFAULT = 8'h24;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
        logic c;
    } flags_t;

    // Bit 5 is hard-wired high and B never exists in the stored register.
    function automatic logic [7:0] fix_p(input logic [7:0] value);
        logic [7:0] fixed;
        fixed           = value;
        fixed[FLAG_ONE] = 1'b1;
        fixed[FLAG_B]   = 1'b0;
        return fixed;
    endfunction

    function automatic logic flag_writable(input logic [2:0] sel);
        logic ok;
        case (sel)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd6: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/bcd_adjust.sv
// Decimal-mode correction of a binary ADC/SBC sum: turns the binary byte and
// its carry/half-carry into a packed-BCD byte and a decimal carry/no-borrow.
module bcd_adjust (
    input  logic [7:0] sum,
    input  logic       carry,
    input  logic       half_carry,
    input  logic       sub,
    output logic [7:0] result,
    output logic       carry_out
);

    logic       lo_adj;
    logic       hi_adj;
    logic [8:0] lo_fix;
    logic [8:0] hi_fix;

    always_comb begin
        lo_adj    = 1'b0;
        hi_adj    = 1'b0;
        lo_fix    = {carry, sum};
        hi_fix    = {carry, sum};
        result    = sum;
        carry_out = carry;
        if (sub) begin
            // A missing carry out of a nibble means that digit borrowed; the
            // binary borrow already propagated, so each digit is fixed in place.
            result[3:0] = half_carry ? sum[3:0] : sum[3:0] - 4'd6;
            result[7:4] = carry ? sum[7:4] : sum[7:4] - 4'd6;
            carry_out   = carry;
        end else begin
            lo_adj    = half_carry || (sum[3:0] > 4'd9);
            lo_fix    = {carry, sum} + (lo_adj ? 9'h006 : 9'h000);
            hi_adj    = lo_fix[8] || (lo_fix[7:4] > 4'd9);
            hi_fix    = lo_fix + (hi_adj ? 9'h060 : 9'h000);
            result    = hi_fix[7:0];
            carry_out = hi_adj;
        end
    end

endmodule

// File: rtl/alu_status.sv
// 6502-style execution stage: combinational 8-bit ALU, status register P and
// the page-crossing latch, all committed on the falling edge of clk.
// Define ALU_DECIMAL_EN to enable BCD correction of ADC/SBC when P.D is set.
module alu_status
    import alu_status_pkg::*;
#(
    parameter logic [7:0] RESET_P = RESET_P_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       alu_en,
    input  logic       p_load,
    input  logic [7:0] dbus,
    input  logic       flag_wr,
    input  logic [2:0] flag_sel,
    input  logic       flag_val,
    output logic [7:0] result,
    output logic [7:0] p,
    output logic       page_cross
);

    logic [7:0] p_p1;
    logic       page_cross_p1;

    logic       carry_in_p0;
    logic [7:0] b_eff_p0;
    logic [8:0] add_sum_p0;
    logic [8:0] ab_sum_p0;
    logic [8:0] cmp_diff_p0;
    logic       arith_v_p0;
    logic [7:0] arith_res_p0;
    logic       arith_c_p0;
    logic [7:0] res_p0;
    flags_t     flags_p0;
    flags_t     upd_p0;
    logic       nz_from_res_p0;
    logic [7:0] p_next_p0;
    logic       pc_vld_p0;

    // Stage p0: operand preparation and the shared 9-bit adders.
    assign carry_in_p0 = p_p1[FLAG_C];
    assign b_eff_p0    = (op == OP_SBC) ? ~b : b;
    assign add_sum_p0  = {1'b0, a} + {1'b0, b_eff_p0} + {8'd0, carry_in_p0};
    assign ab_sum_p0   = {1'b0, a} + {1'b0, b};
    assign cmp_diff_p0 = {1'b0, a} + {1'b0, ~b} + 9'd1;
    assign arith_v_p0  = (a[7] == b_eff_p0[7]) && (add_sum_p0[7] != a[7]);

`ifdef ALU_DECIMAL_EN
    logic [4:0] add_half_p0;
    logic       sub_p0;
    logic       decimal_p0;
    logic [7:0] bcd_res_p0;
    logic       bcd_carry_p0;

    assign add_half_p0 = {1'b0, a[3:0]} + {1'b0, b_eff_p0[3:0]} + {4'd0, carry_in_p0};
    assign sub_p0      = (op == OP_SBC);
    assign decimal_p0  = p_p1[FLAG_D] && ((op == OP_ADC) || (op == OP_SBC));

    bcd_adjust u_bcd_adjust (
        .sum        (add_sum_p0[7:0]),
        .carry      (add_sum_p0[8]),
        .half_carry (add_half_p0[4]),
        .sub        (sub_p0),
        .result     (bcd_res_p0),
        .carry_out  (bcd_carry_p0)
    );

    // V stays binary in decimal mode; only the byte and carry are corrected.
    assign arith_res_p0 = decimal_p0 ? bcd_res_p0 : add_sum_p0[7:0];
    assign arith_c_p0   = decimal_p0 ? bcd_carry_p0 : add_sum_p0[8];
`else
    assign arith_res_p0 = add_sum_p0[7:0];
    assign arith_c_p0   = add_sum_p0[8];
`endif

    always_comb begin
        res_p0         = 8'h00;
        flags_p0       = '0;
        upd_p0         = '0;
        nz_from_res_p0 = 1'b0;
        case (op)
            OP_ADC, OP_SBC: begin
                res_p0         = arith_res_p0;
                flags_p0.c     = arith_c_p0;
                flags_p0.v     = arith_v_p0;
                upd_p0         = '{n: 1'b1, v: 1'b1, z: 1'b1, c: 1'b1};
                nz_from_res_p0 = 1'b1;
            end
            OP_AND, OP_ORA, OP_EOR: begin
                res_p0         = (op == OP_AND) ? (a & b) :
                                 (op == OP_ORA) ? (a | b) : (a ^ b);
                upd_p0         = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b0};
                nz_from_res_p0 = 1'b1;
            end
            OP_ASL, OP_ROL: begin
                res_p0         = {a[6:0], (op == OP_ROL) ? carry_in_p0 : 1'b0};
                flags_p0.c     = a[7];
                upd_p0         = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b1};
                nz_from_res_p0 = 1'b1;
            end
            OP_LSR, OP_ROR: begin
                res_p0         = {(op == OP_ROR) ? carry_in_p0 : 1'b0, a[7:1]};
                flags_p0.c     = a[0];
                upd_p0         = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b1};
                nz_from_res_p0 = 1'b1;
            end
            OP_INC, OP_DEC: begin
                res_p0         = (op == OP_INC) ? a + 8'd1 : a - 8'd1;
                upd_p0         = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b0};
                nz_from_res_p0 = 1'b1;
            end
            OP_CMP: begin
                res_p0     = a;
                flags_p0.c = cmp_diff_p0[8];
                flags_p0.z = (cmp_diff_p0[7:0] == 8'h00);
                flags_p0.n = cmp_diff_p0[7];
                upd_p0     = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b1};
            end
            OP_BIT: begin
                res_p0     = a;
                flags_p0.z = ((a & b) == 8'h00);
                flags_p0.n = b[7];
                flags_p0.v = b[6];
                upd_p0     = '{n: 1'b1, v: 1'b1, z: 1'b1, c: 1'b0};
            end
            OP_PASS: begin
                res_p0         = b;
                upd_p0         = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b0};
                nz_from_res_p0 = 1'b1;
            end
            OP_ADD:    res_p0 = ab_sum_p0[7:0];
            OP_PASSNF: res_p0 = b;
            default:   res_p0 = 8'h00;
        endcase
        if (nz_from_res_p0) begin
            flags_p0.n = res_p0[7];
            flags_p0.z = (res_p0 == 8'h00);
        end
    end

    // Commit selection: p_load replaces P outright; otherwise ALU flags apply
    // first and a single-flag write overlays them.
    always_comb begin
        p_next_p0 = p_p1;
        if (p_load) begin
            p_next_p0 = dbus;
        end else begin
            if (alu_en) begin
                if (upd_p0.n) p_next_p0[FLAG_N] = flags_p0.n;
                if (upd_p0.v) p_next_p0[FLAG_V] = flags_p0.v;
                if (upd_p0.z) p_next_p0[FLAG_Z] = flags_p0.z;
                if (upd_p0.c) p_next_p0[FLAG_C] = flags_p0.c;
            end
            if (flag_wr && flag_writable(flag_sel)) begin
                p_next_p0[flag_sel] = flag_val;
            end
        end
        p_next_p0 = fix_p(p_next_p0);
    end

    assign pc_vld_p0 = alu_en && (op == OP_ADD);

    // Stage p1: architectural state, shared falling edge with the register file.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            p_p1          <= fix_p(RESET_P);
            page_cross_p1 <= 1'b0;
        end else begin
            p_p1 <= p_next_p0;
            if (pc_vld_p0) begin
                page_cross_p1 <= ab_sum_p0[8];
            end
        end
    end

    assign result     = res_p0;
    assign p          = p_p1;
    assign page_cross = page_cross_p1;

endmodule

// File: tb/tb_alu_status.sv
// Self-checking bench for alu_status: directed scenarios plus randomized ops
// compared against an arithmetic reference model of the ALU and status register.
module tb_alu_status;
    import alu_status_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       alu_en;
    logic       p_load;
    logic [7:0] dbus;
    logic       flag_wr;
    logic [2:0] flag_sel;
    logic       flag_val;
    logic [7:0] result;
    logic [7:0] p;
    logic       page_cross;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_p;
    logic       m_pc;

    always #5 clk = ~clk;

    alu_status #(.RESET_P(8'h24)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .a          (a),
        .b          (b),
        .alu_en     (alu_en),
        .p_load     (p_load),
        .dbus       (dbus),
        .flag_wr    (flag_wr),
        .flag_sel   (flag_sel),
        .flag_val   (flag_val),
        .result     (result),
        .p          (p),
        .page_cross (page_cross)
    );

`ifdef ALU_DECIMAL_EN
    function automatic int bcd_val(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction
`endif

    // Reference: result and the P that an alu_en commit would produce.
    function automatic void ref_alu(input logic [3:0] fop, input logic [7:0] fa,
                                    input logic [7:0] fb, input logic [7:0] fp,
                                    output logic [7:0] fr, output logic [7:0] fnp);
        int ai, bi, sa, sb, c, s, sv;
        logic [7:0] q;
        logic nz;
        ai = int'(fa);
        bi = int'(fb);
        sa = int'($signed(fa));
        sb = int'($signed(fb));
        c  = fp[0] ? 1 : 0;
        q  = fp;
        nz = 1'b1;
        fr = 8'h00;
        case (fop)
            4'h0: begin
                s = ai + bi + c;
                sv = sa + sb + c;
                fr = 8'(s);
                q[0] = (s > 255);
                q[6] = (sv > 127) || (sv < -128);
`ifdef ALU_DECIMAL_EN
                if (fp[3]) begin
                    s = bcd_val(fa) + bcd_val(fb) + c;
                    q[0] = (s > 99);
                    fr = to_bcd(s % 100);
                end
`endif
            end
            4'h1: begin
                s = ai - bi - (1 - c);
                sv = sa - sb - (1 - c);
                fr = 8'(s);
                q[0] = (s >= 0);
                q[6] = (sv > 127) || (sv < -128);
`ifdef ALU_DECIMAL_EN
                if (fp[3]) begin
                    s = bcd_val(fa) - bcd_val(fb) - (1 - c);
                    q[0] = (s >= 0);
                    if (s < 0) s = s + 100;
                    fr = to_bcd(s);
                end
`endif
            end
            4'h2: fr = fa & fb;
            4'h3: fr = fa | fb;
            4'h4: fr = fa ^ fb;
            4'h5: begin fr = 8'(ai * 2); q[0] = (ai >= 128); end
            4'h6: begin fr = 8'(ai / 2); q[0] = (ai % 2 == 1); end
            4'h7: begin fr = 8'(ai * 2 + c); q[0] = (ai >= 128); end
            4'h8: begin fr = 8'(ai / 2 + c * 128); q[0] = (ai % 2 == 1); end
            4'h9: fr = 8'((ai + 1) % 256);
            4'hA: fr = 8'((ai + 255) % 256);
            4'hB: begin
                fr = fa; nz = 1'b0;
                q[0] = (ai >= bi);
                q[1] = (ai == bi);
                q[7] = (((ai - bi) & 255) >= 128);
            end
            4'hC: begin
                fr = fa; nz = 1'b0;
                q[1] = ((ai & bi) == 0);
                q[7] = fb[7];
                q[6] = fb[6];
            end
            4'hD: fr = fb;
            4'hE: begin fr = 8'((ai + bi) % 256); nz = 1'b0; end
            default: begin fr = fb; nz = 1'b0; end
        endcase
        if (nz) begin
            q[7] = (fr >= 8'd128);
            q[1] = (fr == 8'd0);
        end
        fnp = q;
    endfunction

    task automatic model_commit();
        logic [7:0] r, np;
        ref_alu(op, a, b, m_p, r, np);
        if (alu_en && op == 4'hE) m_pc = ((int'(a) + int'(b)) > 255);
        if (p_load) begin
            m_p = {dbus[7:6], 2'b10, dbus[3:0]};
        end else begin
            if (alu_en) m_p = np;
            if (flag_wr && (flag_sel inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6}))
                m_p[flag_sel] = flag_val;
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                         input logic en, input logic pl, input logic [7:0] db,
                         input logic fw, input logic [2:0] fs, input logic fv);
        @(posedge clk);
        #1;
        op = o; a = va; b = vb; alu_en = en; p_load = pl; dbus = db;
        flag_wr = fw; flag_sel = fs; flag_val = fv;
    endtask

    task automatic tick();
        model_commit();
        @(negedge clk);
        #1;
    endtask

    task automatic set_flag(input logic [2:0] fs, input logic fv);
        drive(4'hF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, fs, fv);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'hF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        m_p = 8'h24; m_pc = 1'b0;
        #1;
        n_checks++; if (p !== 8'h24) begin n_fail++; $display("FAIL reset_p: got %h expected %h", p, 8'h24); end
        n_checks++; if (page_cross !== 1'b0) begin n_fail++; $display("FAIL reset_pc: got %b expected 0", page_cross); end
        drive(4'hE, 8'hF0, 8'h20, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        tick();
        drive(4'hF, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0);
        tick();
        n_checks++; if (p !== 8'hEF) begin n_fail++; $display("FAIL pre_reset_p: got %h expected %h", p, 8'hEF); end
        // Reset lands mid-cycle while a commit is pending.
        drive(4'h0, 8'h7F, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        #1 reset = 1'b1;
        #1;
        n_checks++; if (p !== 8'h24) begin n_fail++; $display("FAIL midreset_p: got %h expected %h", p, 8'h24); end
        n_checks++; if (page_cross !== 1'b0) begin n_fail++; $display("FAIL midreset_pc: got %b expected 0", page_cross); end
        @(negedge clk);
        #1;
        n_checks++; if (p !== 8'h24) begin n_fail++; $display("FAIL reset_nocommit_p: got %h expected %h", p, 8'h24); end
        n_checks++; if (page_cross !== 1'b0) begin n_fail++; $display("FAIL reset_nocommit_pc: got %b expected 0", page_cross); end
        @(posedge clk);
        #1;
        reset = 1'b0; alu_en = 1'b0; op = 4'hF;
        m_p = 8'h24; m_pc = 1'b0;
    endtask

    task automatic test_adc_overflow();
        set_flag(3'd0, 1'b0);
        drive(4'h0, 8'h7F, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        #1;
        n_checks++; if (result !== 8'h80) begin n_fail++; $display("FAIL adc_result: got %h expected %h", result, 8'h80); end
        tick();
        n_checks++; if ((p & 8'hC3) !== 8'hC0) begin n_fail++; $display("FAIL adc_nvzc: got %h expected %h", p & 8'hC3, 8'hC0); end
        n_checks++; if (p !== m_p) begin n_fail++; $display("FAIL adc_p: got %h expected %h", p, m_p); end
    endtask

    task automatic test_sbc_wrap();
        set_flag(3'd0, 1'b1);
        drive(4'h1, 8'h00, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        #1;
        n_checks++; if (result !== 8'hFF) begin n_fail++; $display("FAIL sbc_result: got %h expected %h", result, 8'hFF); end
        tick();
        n_checks++; if ((p & 8'hC3) !== 8'h80) begin n_fail++; $display("FAIL sbc_nvzc: got %h expected %h", p & 8'hC3, 8'h80); end
    endtask

    task automatic test_cmp_priority();
        drive(4'hB, 8'h40, 8'h40, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
        #1;
        n_checks++; if (result !== 8'h40) begin n_fail++; $display("FAIL cmp_result: got %h expected %h", result, 8'h40); end
        tick();
        n_checks++; if ((p & 8'h83) !== 8'h02) begin n_fail++; $display("FAIL cmp_nzc: got %h expected %h", p & 8'h83, 8'h02); end
    endtask

    task automatic test_page_cross_pload();
        logic [7:0] p_before;
        p_before = m_p;
        drive(4'hE, 8'hF0, 8'h20, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        #1;
        n_checks++; if (result !== 8'h10) begin n_fail++; $display("FAIL add_result: got %h expected %h", result, 8'h10); end
        tick();
        n_checks++; if (page_cross !== 1'b1) begin n_fail++; $display("FAIL add_pc: got %b expected 1", page_cross); end
        n_checks++; if (p !== p_before) begin n_fail++; $display("FAIL add_p_untouched: got %h expected %h", p, p_before); end
        // p_load together with alu_en: the load must win outright.
        drive(4'h0, 8'h7F, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0);
        tick();
        n_checks++; if (p !== 8'hEF) begin n_fail++; $display("FAIL pload_p: got %h expected %h", p, 8'hEF); end
        n_checks++; if (page_cross !== 1'b1) begin n_fail++; $display("FAIL pc_held: got %b expected 1", page_cross); end
    endtask

    task automatic test_flag_write();
        set_flag(3'd7, 1'b0);
        n_checks++; if (p !== 8'hEF) begin n_fail++; $display("FAIL flag_sel7_ignored: got %h expected %h", p, 8'hEF); end
        set_flag(3'd4, 1'b1);
        n_checks++; if (p !== 8'hEF) begin n_fail++; $display("FAIL flag_sel4_ignored: got %h expected %h", p, 8'hEF); end
        set_flag(3'd5, 1'b0);
        n_checks++; if (p !== 8'hEF) begin n_fail++; $display("FAIL flag_sel5_ignored: got %h expected %h", p, 8'hEF); end
        set_flag(3'd2, 1'b0);
        n_checks++; if (p !== 8'hEB) begin n_fail++; $display("FAIL flag_clear_i: got %h expected %h", p, 8'hEB); end
        set_flag(3'd3, 1'b0);
        n_checks++; if (p !== 8'hE3) begin n_fail++; $display("FAIL flag_clear_d: got %h expected %h", p, 8'hE3); end
    endtask

    task automatic test_decimal();
        logic [7:0] exp_r;
        logic       exp_c;
        set_flag(3'd3, 1'b1);
        set_flag(3'd0, 1'b0);
`ifdef ALU_DECIMAL_EN
        exp_r = 8'h04; exp_c = 1'b1;
`else
        exp_r = 8'h9E; exp_c = 1'b0;
`endif
        drive(4'h0, 8'h58, 8'h46, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        #1;
        n_checks++; if (result !== exp_r) begin n_fail++; $display("FAIL dec_adc_result: got %h expected %h", result, exp_r); end
        tick();
        n_checks++; if (p[0] !== exp_c) begin n_fail++; $display("FAIL dec_adc_c: got %b expected %b", p[0], exp_c); end
        n_checks++; if (p !== m_p) begin n_fail++; $display("FAIL dec_adc_p: got %h expected %h", p, m_p); end
`ifdef ALU_DECIMAL_EN
        set_flag(3'd0, 1'b1);
        drive(4'h1, 8'h00, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        #1;
        n_checks++; if (result !== 8'h99) begin n_fail++; $display("FAIL dec_sbc_result: got %h expected %h", result, 8'h99); end
        tick();
        n_checks++; if (p[0] !== 1'b0) begin n_fail++; $display("FAIL dec_sbc_c: got %b expected 0", p[0]); end
`endif
        set_flag(3'd3, 1'b0);
        n_checks++; if (p[3] !== 1'b0) begin n_fail++; $display("FAIL dec_clear_d: got %b expected 0", p[3]); end
    endtask

    task automatic test_random();
        logic [3:0] ro;
        logic [7:0] ra, rb, rd, er, enp;
        logic       ren, rpl, rfw, rfv;
        logic [2:0] rfs;
        for (int i = 0; i < 400; i++) begin
            ro  = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            ren = ($urandom_range(0, 3) != 0);
            rpl = ($urandom_range(0, 7) == 0);
            rd  = 8'($urandom) & 8'hF7;
            rfw = ($urandom_range(0, 3) == 0);
            rfs = 3'($urandom_range(0, 7));
            rfv = 1'($urandom_range(0, 1));
            if (rfs == 3'd3) rfv = 1'b0;
            drive(ro, ra, rb, ren, rpl, rd, rfw, rfs, rfv);
            ref_alu(ro, ra, rb, m_p, er, enp);
            #1;
            n_checks++; if (result !== er) begin n_fail++; $display("FAIL rand_result op=%h a=%h b=%h: got %h expected %h", ro, ra, rb, result, er); end
            tick();
            n_checks++; if (p !== m_p) begin n_fail++; $display("FAIL rand_p op=%h a=%h b=%h: got %h expected %h", ro, ra, rb, p, m_p); end
            n_checks++; if (page_cross !== m_pc) begin n_fail++; $display("FAIL rand_pc op=%h a=%h b=%h: got %b expected %b", ro, ra, rb, page_cross, m_pc); end
        end
    endtask

    initial begin
        reset = 1'b1;
        op = 4'hF; a = 8'h00; b = 8'h00; alu_en = 1'b0; p_load = 1'b0; dbus = 8'h00;
        flag_wr = 1'b0; flag_sel = 3'd0; flag_val = 1'b0;
        m_p = 8'h24; m_pc = 1'b0;
        test_reset();
        test_adc_overflow();
        test_sbc_wrap();
        test_cmp_priority();
        test_page_cross_pload();
        test_flag_write();
        test_decimal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_status.md
Name: alu_status

Overview:
- Execution stage directly downstream of the 6502-alike register file.
- Takes the two register-file read ports as operands and computes an 8-bit result. The result is returned on the register file's write-data input.
- Holds the processor status register P and a page-crossing carry latch used for indexed address arithmetic.
- All state updates on the falling edge of clk, the same edge the register file uses for its writes, so a result and its flags commit together.

Parameters:
- RESET_P, 8'h24, value loaded into P on reset (bit5=1, I=1).

Ports:
- clk  in  1  system clock; state changes on negedge.
- reset  in  1  asynchronous, active-high reset.
- op  in  4  ALU operation select (encodings in alu.vh).
- a  in  8  operand A (register-file read1).
- b  in  8  operand B (register-file read2).
- alu_en  in  1  commit flags of the current op at the next negedge.
- p_load  in  1  load P from dbus at the next negedge (PLP/RTI).
- dbus  in  8  data bus, source for p_load.
- flag_wr  in  1  write a single flag at the next negedge.
- flag_sel  in  3  bit index for flag_wr (0=C,1=Z,2=I,3=D,6=V; 4,5,7 ignored).
- flag_val  in  1  value written by flag_wr.
- result  out  8  combinational ALU result (register-file data input).
- p  out  8  status register {N,V,1,B,D,I,Z,C}.
- page_cross  out  1  latched carry-out of the last committed OP_ADD.

Behaviour:
- Reset, asynchronous:
  - p = RESET_P; page_cross = 0.
  - result stays combinational and is not reset.
  - Reset asserted mid-sequence cancels any pending commit.
- Op codes and results:
  - 0 ADC: a+b+C.
  - 1 SBC: a+~b+C.
  - 2 AND, 3 ORA, 4 EOR.
  - 5 ASL a.
  - 6 LSR a.
  - 7 ROL a: C shifts in at bit0.
  - 8 ROR a: C shifts in at bit7.
  - 9 INC a; A DEC a.
  - B CMP: result = a (unchanged); flags from a-b.
  - C BIT: result = a; Z = (a&b)==0; N = b[7]; V = b[6].
  - D PASS b: sets N, Z.
  - E ADD: a+b with no carry in; P untouched; carry-out goes to page_cross.
  - F PASSNF: b, no flags.
- Flags per op when alu_en:
  - ADC/SBC: N, V, Z, C. V = (a[7]==b'[7]) && (r[7]!=a[7]), where b' = b for ADC, ~b for SBC.
  - Shifts/rotates: N, Z, C (C = bit shifted out).
  - AND/ORA/EOR/INC/DEC/PASS: N, Z only.
  - CMP: C = a>=b (unsigned), Z = a==b, N = (a-b)[7].
- Arithmetic: all sums are 9-bit internally; result is bits [7:0]; wrap-around is natural (FF+01 = 00, C=1).
- Bit 5 of p always reads 1. B always reads 0 in the stored register. p_load ignores dbus[5:4].
- Commit priority at each negedge: reset > p_load > (alu_en flags, then flag_wr overlay).
  - alu_en and flag_wr in the same cycle: both apply; flag_wr wins on the same bit.
  - p_load with alu_en: p_load wins entirely.
  - page_cross updates only when alu_en and op==OP_ADD; it is otherwise held.
- Latency: result is valid combinationally in the same cycle as op/a/b. Flags are visible on p after the following negedge.

Optional Feature:
- Macro: ALU_DECIMAL_EN.
- With the macro defined, when p.D=1, ADC/SBC apply BCD correction:
  - Per-nibble adjust of +6 (ADC) or -6 (SBC).
  - C = decimal carry (ADC) or no-borrow (SBC).
  - N, Z taken from the corrected result; V from the binary computation.
- Without the macro: D is stored and readable but ignored; ADC/SBC are always binary.

Decomposition:
- Shared header alu.vh:
  - OP_* localparams (16 codes).
  - Flag bit indices FLAG_C, FLAG_Z, FLAG_I, FLAG_D, FLAG_B, FLAG_V, FLAG_N.
  - RESET_P default.
- One sub-module, bcd_adjust: 8-bit binary sum, carry and mode in; corrected byte and decimal carry out. It is instantiated only under ALU_DECIMAL_EN.

Test Plan:
- Reset: assert reset mid-cycle with alu_en=1 -> p=8'h24, page_cross=0 immediately, with no commit on the following negedge.
- ADC overflow: C=0, op=ADC, a=8'h7F, b=8'h01, alu_en -> result=8'h80; after negedge N=1, V=1, Z=0, C=0.
- SBC borrow/wrap: C=1, op=SBC, a=8'h00, b=8'h01 -> result=8'hFF, C=0, N=1, Z=0.
- CMP and priority: a=8'h40, b=8'h40, op=CMP, alu_en, with flag_wr sel=0 val=0 in the same cycle -> result=8'h40, Z=1, C=0 (flag_wr overrides C).
- Page cross and p_load:
  - op=ADD, a=8'hF0, b=8'h20, alu_en -> result=8'h10, page_cross=1, p unchanged.
  - Next cycle p_load with dbus=8'hFF -> p=8'hEF.
- Decimal (ALU_DECIMAL_EN): D=1, C=0, ADC a=8'h58, b=8'h46 -> result=8'h04, C=1. Without the macro -> result=8'h9E, C=0.
